// File: rtl/avr109txfifo.sv
// avr109txfifo: byte queue feeding the AVR109 UART transmitter (avr109tx)
// Ports: clk/rst (sync, active-high); wr_data/wr_en enqueue from the core;
//   full/afull/level occupancy flags; overflow sticky (cleared by ovf_clr);
//   tx_data/tx_avail head byte to the transmitter, popped when tx_ready is high.
// Optional: define AVR109TXFIFO_PAUSE_EN to add input pause, which holds off tx_avail.
module avr109txfifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  afull,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_avail,
  input  logic                  tx_ready
`ifdef AVR109TXFIFO_PAUSE_EN
  ,
  input  logic                  pause
`endif
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  always_comb begin
    full = level == (DEPTH_LOG2+1)'(DEPTH);
    afull = level >= (DEPTH_LOG2+1)'(AFULL_LEVEL);
`ifdef AVR109TXFIFO_PAUSE_EN
    tx_avail = (level != '0) & ~pause;
`else
    tx_avail = level != '0;
`endif
    tx_data = mem[rd_ptr];
    push = wr_en & ~full;
    pop = tx_avail & tx_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + DEPTH_LOG2'(pop);
      wr_ptr <= wr_ptr + DEPTH_LOG2'(push);
      level <= level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      overflow <= (wr_en & full) | (overflow & ~ovf_clr);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: tb/tb_avr109txfifo.sv
// tb_avr109txfifo: randomized + directed scoreboard bench for avr109txfifo
module tb_avr109txfifo;
  logic clk = 0, rst = 1, wr_en = 0, ovf_clr = 0, tx_ready = 0, pause = 0;
  logic [7:0] wr_data = 0, tx_data;
  logic full, afull, overflow, tx_avail;
  logic [4:0] level;
  int checks = 0, errors = 0;
  byte unsigned exp_q[$];
  bit exp_ovf = 0;

  avr109txfifo dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
    .afull(afull), .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
    .tx_data(tx_data), .tx_avail(tx_avail), .tx_ready(tx_ready)
`ifdef AVR109TXFIFO_PAUSE_EN
    , .pause(pause)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor + reference model: checks outputs mid-cycle, then applies the
  // inputs the DUT will see at the coming rising edge
  always @(negedge clk) begin
    int n;
    bit avail, popped;
    n = exp_q.size();
    avail = (n != 0);
`ifdef AVR109TXFIFO_PAUSE_EN
    avail = avail && !pause;
`endif
    chk("level", int'(level), n);
    chk("full", int'(full), int'(n == 16));
    chk("afull", int'(afull), int'(n >= 12));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("tx_avail", int'(tx_avail), int'(avail));
    popped = avail && tx_ready;
    if (popped) chk("tx_data", int'(tx_data), int'(exp_q[0]));
    if (rst) begin
      exp_q.delete();
      exp_ovf = 0;
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (wr_en && n < 16) exp_q.push_back(wr_data);
      exp_ovf = (wr_en && n == 16) || (exp_ovf && !ovf_clr);
    end
  end

  task automatic cyc(bit we, byte unsigned d, bit rdy, bit clr = 0, bit r = 0);
    wr_en = we; wr_data = d; tx_ready = rdy; ovf_clr = clr; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) cyc(0, 0, 1);
  endtask

  initial begin
    #1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 8'h41, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hAA, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i + 8'h80), 0);
    cyc(1, 8'h55, 1);
    cyc(0, 0, 0);
    drain();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 40; i++) cyc(1, 8'($urandom), 1);
    drain();
    for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h77, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0);
    drain();
`ifdef AVR109TXFIFO_PAUSE_EN
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hE0 + i), 0);
    pause = 1;
    for (int i = 0; i < 100; i++) cyc(0, 0, 1);
    pause = 0;
    for (int i = 0; i < 6; i++) cyc(0, 0, 1);
`endif
    for (int i = 0; i < 3000; i++) begin
`ifdef AVR109TXFIFO_PAUSE_EN
      pause = ($urandom_range(0, 9) == 0);
`endif
      cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
          $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end
    pause = 0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
